// File: rtl/fir_ctrl_fsm.sv
// Top-level job sequencer of the FIR HWPE: latch config, load taps, run x/y streams, signal done.
// Optional watchdog enabled by defining FIR_CTRL_TIMEOUT_EN.
module fir_ctrl_fsm #(
    parameter int unsigned NB_TAPS        = 16,
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned LEN_W          = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clear_i,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] x_addr_i,
    input  logic [ADDR_W-1:0] h_addr_i,
    input  logic [ADDR_W-1:0] y_addr_i,
    input  logic [4:0]        right_shift_i,
    input  logic [LEN_W-1:0]  signal_length_i,
    input  logic              tap_done_i,
    input  logic              y_valid_i,
    input  logic              y_ready_i,
    input  logic              y_sink_done_i,
    output logic              h_req_start_o,
    output logic              x_req_start_o,
    output logic              y_req_start_o,
    output logic [ADDR_W-1:0] x_addr_o,
    output logic [ADDR_W-1:0] h_addr_o,
    output logic [ADDR_W-1:0] y_addr_o,
    output logic [LEN_W-1:0]  h_length_o,
    output logic [LEN_W-1:0]  xy_length_o,
    output logic [5:0]        right_shift_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o
);

    typedef enum logic [1:0] {StIdle, StTapBuffer, StCompute, StDrain} state_e;

    state_e            state_q, state_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic              h_start_q, h_start_d;
    logic              xy_start_q, xy_start_d;
    logic              done_q, done_d;
    logic              latch;
    logic              hs;
    logic [ADDR_W-1:0] x_addr_q, h_addr_q, y_addr_q;
    logic [LEN_W-1:0]  len_q;
    logic [4:0]        shift_q;

    assign hs = y_valid_i & y_ready_i;

`ifdef FIR_CTRL_TIMEOUT_EN
    localparam int unsigned WdW = $clog2(TIMEOUT_CYCLES + 1);
    logic [WdW-1:0] wd_q, wd_d;
    logic           err_q, err_d;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        h_start_d  = 1'b0;
        xy_start_d = 1'b0;
        done_d     = 1'b0;
        latch      = 1'b0;
        if (clear_i) begin
            state_d = StIdle;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        latch = 1'b1;
                        if (signal_length_i == '0) begin
                            done_d = 1'b1;
                        end else begin
                            h_start_d = 1'b1;
                            state_d   = StTapBuffer;
                        end
                    end
                end
                StTapBuffer: begin
                    if (tap_done_i) begin
                        xy_start_d = 1'b1;
                        cnt_d      = '0;
                        state_d    = StCompute;
                    end
                end
                StCompute: begin
                    if (hs) begin
                        cnt_d = cnt_q + LEN_W'(1);
                        if (cnt_q == len_q - LEN_W'(1)) begin
                            state_d = StDrain;
                        end
                    end
                end
                StDrain: begin
                    if (y_sink_done_i) begin
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end

`ifdef FIR_CTRL_TIMEOUT_EN
        // Watchdog restarts on any progress: a state change or a counted output.
        wd_d  = '0;
        err_d = 1'b0;
        if (!clear_i && state_q != StIdle && state_d == state_q
            && !(state_q == StCompute && hs)) begin
            if (wd_q == WdW'(TIMEOUT_CYCLES - 1)) begin
                err_d   = 1'b1;
                state_d = StIdle;
                cnt_d   = '0;
            end else begin
                wd_d = wd_q + WdW'(1);
            end
        end
`endif
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            h_start_q  <= 1'b0;
            xy_start_q <= 1'b0;
            done_q     <= 1'b0;
            x_addr_q   <= '0;
            h_addr_q   <= '0;
            y_addr_q   <= '0;
            len_q      <= '0;
            shift_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            h_start_q  <= h_start_d;
            xy_start_q <= xy_start_d;
            done_q     <= done_d;
            if (latch) begin
                x_addr_q <= x_addr_i;
                h_addr_q <= h_addr_i;
                y_addr_q <= y_addr_i;
                len_q    <= signal_length_i;
                shift_q  <= right_shift_i;
            end
        end
    end

`ifdef FIR_CTRL_TIMEOUT_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wd_q  <= '0;
            err_q <= 1'b0;
        end else begin
            wd_q  <= wd_d;
            err_q <= err_d;
        end
    end
    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

    assign h_req_start_o = h_start_q;
    assign x_req_start_o = xy_start_q;
    assign y_req_start_o = xy_start_q;
    assign x_addr_o      = x_addr_q;
    assign h_addr_o      = h_addr_q;
    assign y_addr_o      = y_addr_q;
    assign h_length_o    = LEN_W'(NB_TAPS);
    assign xy_length_o   = len_q;
    assign right_shift_o = {1'b0, shift_q};
    assign busy_o        = (state_q != StIdle);
    assign done_o        = done_q;

endmodule

// File: tb/tb_fir_ctrl_fsm.sv
// Directed bench for fir_ctrl_fsm; inputs driven and outputs sampled on the falling edge.
module tb_fir_ctrl_fsm;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        clear_i, start_i;
    logic [31:0] x_addr_i, h_addr_i, y_addr_i;
    logic [4:0]  right_shift_i;
    logic [15:0] signal_length_i;
    logic        tap_done_i, y_valid_i, y_ready_i, y_sink_done_i;
    logic        h_req_start_o, x_req_start_o, y_req_start_o;
    logic [31:0] x_addr_o, h_addr_o, y_addr_o;
    logic [15:0] h_length_o, xy_length_o;
    logic [5:0]  right_shift_o;
    logic        busy_o, done_o, err_o;

    int total = 0;
    int bad   = 0;
    int h_n = 0, x_n = 0, y_n = 0, done_n = 0, err_n = 0, busy_n = 0;
    int h0, x0, y0, d0, e0, b0;

    fir_ctrl_fsm #(
        .NB_TAPS       (16),
        .ADDR_W        (32),
        .LEN_W         (16),
        .TIMEOUT_CYCLES(32)
    ) u_dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .clear_i        (clear_i),
        .start_i        (start_i),
        .x_addr_i       (x_addr_i),
        .h_addr_i       (h_addr_i),
        .y_addr_i       (y_addr_i),
        .right_shift_i  (right_shift_i),
        .signal_length_i(signal_length_i),
        .tap_done_i     (tap_done_i),
        .y_valid_i      (y_valid_i),
        .y_ready_i      (y_ready_i),
        .y_sink_done_i  (y_sink_done_i),
        .h_req_start_o  (h_req_start_o),
        .x_req_start_o  (x_req_start_o),
        .y_req_start_o  (y_req_start_o),
        .x_addr_o       (x_addr_o),
        .h_addr_o       (h_addr_o),
        .y_addr_o       (y_addr_o),
        .h_length_o     (h_length_o),
        .xy_length_o    (xy_length_o),
        .right_shift_o  (right_shift_o),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .err_o          (err_o)
    );

    always #5 clk_i = ~clk_i;

    always @(negedge clk_i) begin
        if (h_req_start_o) h_n++;
        if (x_req_start_o) x_n++;
        if (y_req_start_o) y_n++;
        if (done_o) done_n++;
        if (err_o) err_n++;
        if (busy_o) busy_n++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk_i);
    endtask

    task automatic snap();
        h0 = h_n; x0 = x_n; y0 = y_n; d0 = done_n; e0 = err_n; b0 = busy_n;
    endtask

    task automatic start_job(input logic [15:0] len);
        x_addr_i        = 32'h1000_0000 + 32'(len);
        h_addr_i        = 32'h2000_0000 + 32'(len);
        y_addr_i        = 32'h3000_0000 + 32'(len);
        right_shift_i   = 5'(len) + 5'd3;
        signal_length_i = len;
        start_i         = 1'b1;
        tick();
        start_i         = 1'b0;
    endtask

    task automatic handshakes(input int n);
        y_valid_i = 1'b1;
        y_ready_i = 1'b1;
        repeat (n) tick();
        y_valid_i = 1'b0;
        y_ready_i = 1'b0;
    endtask

    task automatic finish_drain();
        y_sink_done_i = 1'b1;
        tick();
        y_sink_done_i = 1'b0;
        check("drain_done", {30'd0, done_o, busy_o}, 32'd2);
    endtask

    initial begin
        rst_ni = 1'b0; clear_i = 1'b0; start_i = 1'b0;
        x_addr_i = '0; h_addr_i = '0; y_addr_i = '0; right_shift_i = '0; signal_length_i = '0;
        tap_done_i = 1'b0; y_valid_i = 1'b0; y_ready_i = 1'b0; y_sink_done_i = 1'b0;
        repeat (2) tick();
        check("rst_outs", {26'd0, busy_o, done_o, err_o, h_req_start_o, x_req_start_o,
                           y_req_start_o}, 32'd0);
        check("rst_addr", x_addr_o | h_addr_o | y_addr_o, 32'd0);
        check("rst_len", {xy_length_o, 10'd0, right_shift_o}, 32'd0);
        check("h_length", {16'd0, h_length_o}, 32'd16);
        rst_ni = 1'b1;
        tick();

        // 1: nominal job, len=8
        snap();
        start_job(16'd8);
        check("t1_hstart", {30'd0, h_req_start_o, busy_o}, 32'd3);
        check("t1_xaddr", x_addr_o, 32'h1000_0008);
        check("t1_yaddr", y_addr_o, 32'h3000_0008);
        check("t1_cfg", {xy_length_o, 10'd0, right_shift_o}, {16'd8, 10'd0, 6'd11});
        repeat (15) tick();
        check("t1_no_xstart", {31'd0, x_req_start_o}, 32'd0);
        tap_done_i = 1'b1;
        tick();
        tap_done_i = 1'b0;
        check("t1_xystart", {30'd0, x_req_start_o, y_req_start_o}, 32'd3);
        handshakes(8);
        check("t1_pre_done", {30'd0, done_o, busy_o}, 32'd1);
        finish_drain();
        tick();
        check("t1_done_low", {31'd0, done_o}, 32'd0);
        check("t1_pulses", {8'(h_n - h0), 8'(x_n - x0), 8'(y_n - y0), 8'(done_n - d0)},
              32'h0101_0101);
        check("t1_busy_cycles", 32'(busy_n - b0), 32'd25);

        // 2: zero-length job
        snap();
        start_job(16'd0);
        check("t2_done", {30'd0, done_o, busy_o}, 32'd2);
        tick();
        tick();
        check("t2_no_starts", 32'((h_n - h0) + (x_n - x0) + (y_n - y0) + (busy_n - b0)), 32'd0);
        check("t2_done_once", 32'(done_n - d0), 32'd1);

        // 3: start re-pulsed while busy is ignored
        snap();
        start_job(16'd4);
        tick();
        start_job(16'd9);
        check("t3_len_kept", {16'd0, xy_length_o}, 32'd4);
        tap_done_i = 1'b1;
        tick();
        tap_done_i = 1'b0;
        start_i = 1'b1;
        signal_length_i = 16'd9;
        y_valid_i = 1'b1; y_ready_i = 1'b1;
        tick();
        start_i = 1'b0;
        handshakes(3);
        finish_drain();
        tick();
        check("t3_single", {8'(h_n - h0), 8'(done_n - d0), 16'(xy_length_o)}, 32'h0101_0004);

        // 4: y_ready toggling, len=5
        snap();
        start_job(16'd5);
        tap_done_i = 1'b1;
        tick();
        tap_done_i = 1'b0;
        y_valid_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            y_ready_i = (i % 2 == 0);
            tick();
        end
        y_ready_i = 1'b0;
        y_sink_done_i = 1'b1;
        tick();
        y_sink_done_i = 1'b0;
        check("t4_after4", {30'd0, done_o, busy_o}, 32'd1);
        y_ready_i = 1'b1;
        tick();
        y_ready_i = 1'b0;
        y_valid_i = 1'b0;
        finish_drain();

        // 5: clear in COMPUTE at count 3, then a len=2 job and back-to-back restart
        tick();
        snap();
        start_job(16'd8);
        tap_done_i = 1'b1;
        tick();
        tap_done_i = 1'b0;
        handshakes(3);
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        check("t5_cleared", {30'd0, done_o, busy_o}, 32'd0);
        repeat (3) tick();
        check("t5_no_done", 32'(done_n - d0), 32'd0);
        check("t5_cfg_kept", {16'd0, xy_length_o}, 32'd8);
        start_job(16'd2);
        tap_done_i = 1'b1;
        tick();
        tap_done_i = 1'b0;
        handshakes(2);
        y_sink_done_i = 1'b1;
        tick();
        y_sink_done_i = 1'b0;
        check("t5_job2_done", {30'd0, done_o, busy_o}, 32'd2);
        start_job(16'd3);
        check("t5_restart", {30'd0, h_req_start_o, busy_o}, 32'd3);

        // async reset mid-job zeroes config
        rst_ni = 1'b0;
        #1;
        check("arst_state", {31'd0, busy_o}, 32'd0);
        check("arst_cfg", x_addr_o | {16'd0, xy_length_o}, 32'd0);
        tick();
        rst_ni = 1'b1;
        tick();

        // 6: stalled tap load
        snap();
        start_job(16'd1);
        repeat (40) tick();
`ifdef FIR_CTRL_TIMEOUT_EN
        check("t6_err_once", 32'(err_n - e0), 32'd1);
        check("t6_idle", {30'd0, busy_o, 1'b0}, 32'd0);
`else
        check("t6_no_err", 32'(err_n - e0), 32'd0);
        check("t6_stall", {31'd0, busy_o}, 32'd1);
`endif
        check("t6_no_done", 32'(done_n - d0), 32'd0);
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
